// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one fixed-latency data memory between the pipeline MEM stage and a
//   debug/loader port. Each access is issued in a single IDLE cycle and then
//   occupies the memory for LAT further cycles. The pipeline is stalled until
//   its own access completes, so the MEM/WB register captures load data on the
//   completion edge.
//
// Parameters
//   LAT      memory latency in cycles from issue to valid m_rdata (1..7)
//
// Ports
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   p_req/p_we/p_addr/p_wdata   pipeline request, held while stalled
//   p_rdata                     pipeline load data, valid in the completion cycle
//   p_stall                     freezes pipeline stages up to and including MEM
//   d_req/d_we/d_addr/d_wdata   debug/loader request, held until completion
//   d_rdata                     registered debug read data
//   d_ack                       one-cycle debug completion pulse
//   m_en/m_we/m_addr/m_wdata    memory strobe and request fields (issue cycle only)
//   m_rdata                     memory read data, valid LAT cycles after m_en

module dmem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_P, OWN_D} port_t;

  // The counter is loaded at issue so that it reaches zero exactly LAT cycles later.
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  state_t     state;
  port_t      owner;
  port_t      last;
  logic [2:0] cnt;

  logic any_req;
  logic issue;
  logic grant_d;
  logic complete;
  logic p_done;

  // Arbitration and completion decode. On contention the port that did not
  // win the previous grant goes next, so neither side can be starved.
  always_comb begin
    any_req  = p_req | d_req;
    issue    = ~reset & (state == IDLE) & any_req;
    grant_d  = d_req & (~p_req | (last == OWN_P));
    complete = ~reset & (state == BUSY) & (cnt == 3'd0);
    p_done   = complete & (owner == OWN_P);
  end

  // Memory request fields come straight from the granted port during the
  // issue cycle and are forced to zero at all other times.
  always_comb begin
    m_en    = issue;
    m_we    = 1'b0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (issue) begin
      if (grant_d) begin
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else begin
        m_we    = p_we;
        m_addr  = p_addr;
        m_wdata = p_wdata;
      end
    end
  end

  // Pipeline side: load data is a pass-through in its completion cycle, and
  // the stall drops in that same cycle so MEM/WB captures on this edge. A
  // flushed request (p_req low) never stalls.
  assign p_rdata = p_done ? m_rdata : 32'h0;
  assign p_stall = p_req & ~reset & ~p_done;

  // Access sequencer. Debug completion is reported one cycle late through the
  // registered d_ack/d_rdata, and is suppressed if the requester gave up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      owner   <= OWN_P;
      last    <= OWN_D;
      d_rdata <= 32'h0;
      d_ack   <= 1'b0;
    end else begin
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= BUSY;
            owner <= grant_d ? OWN_D : OWN_P;
            last  <= grant_d ? OWN_D : OWN_P;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt == 3'd0) begin
            state <= IDLE;
            if ((owner == OWN_D) && d_req) begin
              d_ack <= 1'b1;
              if (!d_we) begin
                d_rdata <= m_rdata;
              end
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Data-memory access controller for the 32-bit pipeline's MEM stage. It shares one fixed-latency data memory between the pipeline load/store path and a debug/loader port. It sequences each access with a small state machine and stalls the pipeline until the pipeline's access completes, so the MEM/WB register captures load data on the completion edge.

## Interface
- LAT, 2, memory latency in cycles from issue to valid `m_rdata`/write commit; legal range 1..7
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- p_req  in  1  pipeline access request; held by MEM stage while stalled
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  32  pipeline address
- p_wdata  in  32  pipeline store data
- p_rdata  out  32  pipeline load data, valid in completion cycle
- p_stall  out  1  freeze pipeline stages up to and including MEM
- d_req  in  1  debug/loader request; held until `d_ack`
- d_we  in  1  debug write / read
- d_addr  in  32  debug address
- d_wdata  in  32  debug write data
- d_rdata  out  32  registered debug read data
- d_ack  out  1  one-cycle completion pulse for the debug port
- m_en  out  1  memory access strobe, one cycle per access
- m_we  out  1  memory write enable, qualified by `m_en`
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid LAT cycles after the `m_en` cycle

## Operation
- States: IDLE, BUSY. Registers: `owner` (P/D), `last` (P/D), 3-bit `cnt`.
- IDLE with any request: grant, drive `m_en=1`, `m_we/m_addr/m_wdata` from the granted port (combinational, same cycle). Load `cnt=LAT-1`, set `owner` and `last`, go BUSY.
- Arbitration in IDLE: a single requester wins. If both request, grant the port not equal to `last`. `last` resets to D, so the pipeline wins the first contention.
- BUSY: `m_en=0`. `m_addr/m_wdata/m_we` are 0 outside the issue cycle. `cnt` decrements each cycle. The completion cycle is BUSY with `cnt==0`; the next state is IDLE.
- Completion, owner P: `p_rdata=m_rdata` (combinational pass-through, 0 otherwise). `p_stall` deasserts this cycle, so the MEM/WB register captures at this edge.
- Completion, owner D: register `d_rdata<=m_rdata` on reads; `d_rdata` is unchanged on writes. Pulse `d_ack=1` in the following cycle.
- `p_stall = p_req & ~reset & ~(BUSY & owner==P & cnt==0)`. This includes cycles lost to contention with D.
- Pipeline flush (`p_req` drops while owner P is in flight): the memory access still runs to completion, the result is discarded, and `p_stall` follows `p_req` (0).
- `d_req` dropped before completion: the access completes and `d_ack` is suppressed.
- Back-to-back: the earliest next issue is the cycle after completion. Per-access occupancy is LAT+1 cycles.

## Timing
- Reset values: state IDLE, `cnt=0`, `owner=P`, `last=D`, `d_rdata=0`, `d_ack=0`. `m_en/m_we/m_addr/m_wdata/p_rdata` are 0 and `p_stall=0` while `reset` is high.
- Pipeline access issued at cycle t: `p_stall=1` for cycles t..t+LAT-1 and 0 at t+LAT (completion). A new access can issue at t+LAT+1.
- Debug access issued at t: `d_rdata` updated and `d_ack=1` at t+LAT+1.
- Reset mid-BUSY: the next cycle is IDLE, the in-flight result is dropped, and there is no `d_ack` or completion.
- Requesters must hold req/we/addr/wdata stable until completion/ack. The block does not latch request fields beyond the issue cycle.

## Test plan
- LAT=2, single pipeline load, `p_addr=0x10`, memory returns 0xDEADBEEF: `m_en` is high at t only, `p_stall` is 1 at t and t+1 and 0 at t+2, and `p_rdata=0xDEADBEEF` at t+2.
- Simultaneous `p_req`/`d_req` out of reset: P is granted first (issue t), D issues at t+3 with `d_ack` at t+6. `p_stall` stays high from t through t+1, then goes low.
- Alternation under continuous contention: grants go P, D, P, D across four accesses, with `last` toggling each issue.
- Debug write `d_addr=0x40`, `d_wdata=0x12345678`: `m_we=1` and `m_addr=0x40` at issue, and `d_ack` pulses exactly one cycle at issue+LAT+1 with `d_rdata` unchanged.
- Pipeline flush: drop `p_req` at t+1 of a P access. Expect `p_stall=0` from t+1, no state corruption, and a D request pending at t+1 issues at t+LAT+1.
- Assert `reset` at t+1 of a D read: at t+2 the state is IDLE, `d_ack` never pulses, `d_rdata=0`, and a fresh request issues in the first cycle after reset deasserts.
